demux_key_router: RTL and testbench
===================================

// Module: demux_key_router
// PURPOSE
//  Keyed 1-to-N stream demultiplexer; the inverse of the keyed lookup mux. One valid/ready input
//  stream carries a key and data. The key is matched against a flat key table. Data is delivered
//  into a one-entry buffer on the matching output channel. Sits between a producer, e.g. a decoded
//  keyboard/ALU result, and up to NR_KEY consumers, e.g. 7-seg or LED drivers.
// PARAMETERS
//  NR_KEY    4   number of output channels / table entries
//  KEY_LEN   2   key width in bits
//  DATA_LEN  1   data width in bits
//  CNT_W     8   width of miss counter (used only with DEMUX_MISS_CNT_EN)
// PORTS
//  clk        in   1                  single clock; all state updates on rising edge
//  rst        in   1                  reset, asynchronous, active-high
//  in_valid   in   1                  input beat present
//  in_ready   out  1                  input beat accepted this cycle when in_valid & in_ready
//  in_key     in   KEY_LEN            routing key of input beat
//  in_data    in   DATA_LEN           payload of input beat
//  key_lut    in   NR_KEY*KEY_LEN     key table; entry n = key_lut[KEY_LEN*(n+1)-1 -: KEY_LEN]
//  out_valid  out  NR_KEY             bit n: channel n buffer holds a beat
//  out_ready  in   NR_KEY             bit n: consumer n takes beat when out_valid[n]
//  out_data   out  NR_KEY*DATA_LEN    channel n payload at [DATA_LEN*(n+1)-1 -: DATA_LEN]
//  miss       out  1                  one-cycle pulse: an unmatched beat was dropped
//  miss_cnt   out  CNT_W              saturating count of dropped beats (macro only)
// BEHAVIOUR
//  - Reset, async assert: out_valid=0, out_data=0, miss=0, miss_cnt=0 immediately. Buffered beats
//    are discarded. A beat offered during reset is not accepted.
//  - Match: hit[n] = (in_key == key_table[n]). Duplicate keys: the lowest n wins (priority, not OR).
//  - in_ready is combinational:
//      hit on channel s: in_ready = !out_valid[s] | out_ready[s]
//      no hit:           in_ready = 1 (beat is dropped)
//    in_ready never depends on in_valid.
//  - Accept on channel s: at the next edge, out_valid[s]=1 and out_data[s]=in_data.
//    Latency is 1 cycle; there is no combinational in->out data path.
//  - Drain: out_valid[n] & out_ready[n] with no refill on n -> out_valid[n]=0 next edge.
//    out_data holds its last value.
//  - Drain and fill on the same channel in the same cycle: new beat loads, out_valid stays 1.
//    Full throughput is 1 beat/cycle per channel.
//  - Channels are independent: a stalled channel s blocks only beats keyed to s.
//    The input is in-order, so head-of-line blocking applies.
//  - Each slot's state machine has 2 states:
//      EMPTY -> FULL  on accept
//      FULL  -> EMPTY on drain without accept
//      FULL  -> FULL  on drain+accept or on no drain
//  - Miss: in_valid & no hit -> miss=1 for exactly that cycle, registered, visible next cycle.
//    Data is discarded.
//  - key_lut is sampled combinationally each cycle. Changing it does not affect beats already buffered.
// CONFIGURATION
//  DEMUX_MISS_CNT_EN defined:
//   - miss_cnt increments on every dropped beat and saturates at 2^CNT_W-1.
//   - Only rst clears it.
//  DEMUX_MISS_CNT_EN undefined:
//   - miss_cnt port is still present and tied to 0.
//   - No counter logic; the miss pulse is unchanged.
// STRUCTURE
//  - Package demux_key_pkg:
//      PAIR_LEN helper
//      slot state encoding (SLOT_EMPTY=1'b0, SLOT_FULL=1'b1)
//      function for lowest-index one-hot priority select
//  - Sub-module demux_slot #(DATA_LEN):
//      one-entry buffer
//      ports: clk, rst, load, load_data, out_ready, out_valid, out_data, can_load
//      instantiated NR_KEY times in a generate loop
//  - Top level: key compare, priority select, in_ready mux, miss logic, optional counter.
// TESTING
//  - Reset: assert rst mid-stream with out_valid=4'b0101 -> all outputs 0 in the same cycle
//    without a clock edge; miss_cnt=0.
//  - Basic route: key_lut={2'b11,2'b10,2'b01,2'b00}, in_key=2'b10, in_data=1, out_ready=0
//    -> next cycle out_valid=4'b0100, channel 2 data=1.
//  - Backpressure: channel 2 full, out_ready[2]=0, second beat key=2'b10 -> in_ready=0.
//    Raise out_ready[2] -> in_ready=1, beat loads in the same cycle as the drain,
//    and out_valid[2] stays 1.
//  - Independence: channel 2 stalled, beat key=2'b00 -> in_ready=1, out_valid[0]=1 next cycle.
//  - Miss: key_lut={2'b00,2'b00,2'b01,2'b00}, in_key=2'b11
//    -> in_ready=1, miss pulses 1 cycle, out_valid unchanged.
//    With the macro, 300 misses on CNT_W=8 -> miss_cnt=255.
//  - Duplicate key: same key_lut, in_key=2'b00 -> only channel 0 loads.
//  - Streaming: out_ready=all 1, 16 back-to-back beats cycling keys 0..3
//    -> each channel sees its 4 beats in order, and in_ready stays 1 throughout.

Source files
------------

// File: rtl/demux_key_pkg.sv
// rtl/demux_key_pkg.sv - shared types and helpers for the keyed stream demultiplexer
package demux_key_pkg;

  function automatic int pair_len(input int key_len, input int data_len);
    return key_len + data_len;
  endfunction

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Isolates the lowest set bit so duplicate table keys resolve to the lowest channel.
  function automatic logic [31:0] lowest_onehot(input logic [31:0] v);
    return v & (~v + 32'd1);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output buffer with a two-state occupancy machine
module demux_slot
  import demux_key_pkg::*;
#(
  parameter int DATA_LEN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [DATA_LEN-1:0] load_data,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DATA_LEN-1:0] out_data,
  output logic                can_load
);

  slot_state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SLOT_EMPTY;
      out_data <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: if (load) state <= SLOT_FULL;
        SLOT_FULL:  if (out_ready && !load) state <= SLOT_EMPTY;
        default:    state <= SLOT_EMPTY;
      endcase
      // Payload only changes on a load; a plain drain leaves the last value visible.
      if (load) out_data <= load_data;
    end
  end

  assign out_valid = (state == SLOT_FULL);
  assign can_load  = !out_valid || out_ready;

endmodule

// File: rtl/demux_key_router.sv
// rtl/demux_key_router.sv - keyed 1-to-N stream demux; DEMUX_MISS_CNT_EN adds a saturating miss counter
module demux_key_router
  import demux_key_pkg::*;
#(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 1,
  parameter int CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [KEY_LEN-1:0]         in_key,
  input  logic [DATA_LEN-1:0]        in_data,
  input  logic [NR_KEY*KEY_LEN-1:0]  key_lut,
  output logic [NR_KEY-1:0]          out_valid,
  input  logic [NR_KEY-1:0]          out_ready,
  output logic [NR_KEY*DATA_LEN-1:0] out_data,
  output logic                       miss,
  output logic [CNT_W-1:0]           miss_cnt
);

  logic [NR_KEY-1:0] hit;
  logic [NR_KEY-1:0] sel;
  logic [NR_KEY-1:0] can_load;
  logic [NR_KEY-1:0] load;
  logic              any_hit;
  logic              accept;
  logic              drop;

  for (genvar n = 0; n < NR_KEY; n++) begin : g_match
    assign hit[n] = (in_key == key_lut[KEY_LEN*(n+1)-1 -: KEY_LEN]);
  end

  assign sel     = NR_KEY'(lowest_onehot(32'(hit)));
  assign any_hit = |hit;
  // Unmatched beats are always taken so they never block the stream.
  assign in_ready = any_hit ? |(sel & can_load) : 1'b1;
  assign accept   = in_valid && in_ready;
  assign drop     = in_valid && !any_hit;
  assign load     = accept ? sel : '0;

  for (genvar n = 0; n < NR_KEY; n++) begin : g_slot
    demux_slot #(.DATA_LEN(DATA_LEN)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[n]),
      .load_data (in_data),
      .out_ready (out_ready[n]),
      .out_valid (out_valid[n]),
      .out_data  (out_data[DATA_LEN*(n+1)-1 -: DATA_LEN]),
      .can_load  (can_load[n])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) miss <= 1'b0;
    else     miss <= drop;
  end

`ifdef DEMUX_MISS_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             miss_cnt <= '0;
    else if (drop && miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + 1'b1;
  end
`else
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_key_router.sv
// tb/tb_demux_key_router.sv - directed vector bench for demux_key_router
module tb_demux_key_router;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_key;
  logic [0:0] in_data;
  logic [7:0] key_lut;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [3:0] out_data;
  logic       miss;
  logic [7:0] miss_cnt;

  demux_key_router #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(1), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_key    (in_key),
    .in_data   (in_data),
    .key_lut   (key_lut),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .miss      (miss),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] LUT_A = 8'b11_10_01_00;
  localparam logic [7:0] LUT_B = 8'b00_00_01_00;
`ifdef DEMUX_MISS_CNT_EN
  localparam logic [7:0] CNT_SAT = 8'd255;
`else
  localparam logic [7:0] CNT_SAT = 8'd0;
`endif

  typedef struct {
    logic       v;
    logic [1:0] k;
    logic       d;
    logic [7:0] lut;
    logic [3:0] ordy;
    logic       rdy;
    logic [3:0] ov;
    logic [3:0] od;
    logic       ms;
  } vec_t;

  vec_t vec [14];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [1:0] k, input logic d,
                       input logic [7:0] lut, input logic [3:0] ordy);
    in_valid  = v;
    in_key    = k;
    in_data   = d;
    key_lut   = lut;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] onehot;
    logic       d;

    // Each row: inputs, then in_ready before the edge and registered outputs after it.
    vec[0]  = '{1'b1, 2'd2, 1'b1, LUT_A, 4'b0000, 1'b1, 4'b0100, 4'b0100, 1'b0};
    vec[1]  = '{1'b1, 2'd2, 1'b0, LUT_A, 4'b0000, 1'b0, 4'b0100, 4'b0100, 1'b0};
    vec[2]  = '{1'b1, 2'd2, 1'b0, LUT_A, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b0};
    vec[3]  = '{1'b1, 2'd0, 1'b1, LUT_A, 4'b0000, 1'b1, 4'b0101, 4'b0001, 1'b0};
    vec[4]  = '{1'b1, 2'd1, 1'b1, LUT_A, 4'b0000, 1'b1, 4'b0111, 4'b0011, 1'b0};
    vec[5]  = '{1'b1, 2'd1, 1'b0, LUT_A, 4'b0000, 1'b0, 4'b0111, 4'b0011, 1'b0};
    vec[6]  = '{1'b0, 2'd3, 1'b1, LUT_A, 4'b0010, 1'b1, 4'b0101, 4'b0011, 1'b0};
    vec[7]  = '{1'b1, 2'd3, 1'b1, LUT_B, 4'b0000, 1'b1, 4'b0101, 4'b0011, 1'b1};
    vec[8]  = '{1'b0, 2'd3, 1'b0, LUT_B, 4'b0000, 1'b1, 4'b0101, 4'b0011, 1'b0};
    vec[9]  = '{1'b0, 2'd3, 1'b0, LUT_B, 4'b1111, 1'b1, 4'b0000, 4'b0011, 1'b0};
    vec[10] = '{1'b1, 2'd0, 1'b0, LUT_B, 4'b0000, 1'b1, 4'b0001, 4'b0010, 1'b0};
    vec[11] = '{1'b1, 2'd0, 1'b1, LUT_B, 4'b0000, 1'b0, 4'b0001, 4'b0010, 1'b0};
    vec[12] = '{1'b1, 2'd1, 1'b1, LUT_B, 4'b0001, 1'b1, 4'b0010, 4'b0010, 1'b0};
    vec[13] = '{1'b0, 2'd0, 1'b0, LUT_B, 4'b1111, 1'b1, 4'b0000, 4'b0010, 1'b0};

    rst = 1'b1;
    drive(1'b0, 2'd0, 1'b0, LUT_A, 4'b0000);
    #3;
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_data", 32'(out_data), 32'h0);
    chk("reset_miss", 32'(miss), 32'h0);
    chk("reset_miss_cnt", 32'(miss_cnt), 32'h0);
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(vec[i].v, vec[i].k, vec[i].d, vec[i].lut, vec[i].ordy);
      #4;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vec[i].rdy));
      tick();
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vec[i].ov));
      chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vec[i].od));
      chk($sformatf("vec%0d_miss", i), 32'(miss), 32'(vec[i].ms));
    end

    // Back-to-back streaming: every channel drains each cycle, in_ready never drops.
    for (int i = 0; i < 16; i++) begin
      d = 1'(((i >> 2) ^ i) & 1);
      onehot = 4'b0001 << (i % 4);
      drive(1'b1, 2'(i % 4), d, LUT_A, 4'b1111);
      #4;
      chk($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'h1);
      tick();
      chk($sformatf("stream%0d_out_valid", i), 32'(out_valid), 32'(onehot));
      chk($sformatf("stream%0d_data", i), 32'(out_data[i % 4]), 32'(d));
    end
    drive(1'b0, 2'd0, 1'b0, LUT_A, 4'b1111);
    tick();
    chk("stream_drained", 32'(out_valid), 32'h0);

    // Miss flood to push the counter into saturation.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'd3, 1'b1, LUT_B, 4'b0000);
      tick();
    end
    drive(1'b0, 2'd0, 1'b0, LUT_B, 4'b0000);
    chk("flood_miss_high", 32'(miss), 32'h1);
    chk("flood_no_load", 32'(out_valid), 32'h0);
    tick();
    chk("flood_miss_cnt", 32'(miss_cnt), 32'(CNT_SAT));
    chk("flood_miss_low", 32'(miss), 32'h0);

    // Mid-stream asynchronous reset with buffered beats and a live miss pulse.
    drive(1'b1, 2'd0, 1'b1, LUT_A, 4'b0000);
    tick();
    drive(1'b1, 2'd2, 1'b1, LUT_A, 4'b0000);
    tick();
    drive(1'b1, 2'd3, 1'b0, LUT_B, 4'b0000);
    tick();
    chk("pre_reset_out_valid", 32'(out_valid), 32'h5);
    chk("pre_reset_miss", 32'(miss), 32'h1);
    drive(1'b1, 2'd1, 1'b1, LUT_A, 4'b0000);
    #2;
    rst = 1'b1;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'h0);
    chk("async_out_data", 32'(out_data), 32'h0);
    chk("async_miss", 32'(miss), 32'h0);
    chk("async_miss_cnt", 32'(miss_cnt), 32'h0);
    tick();
    chk("reset_no_accept", 32'(out_valid), 32'h0);
    rst = 1'b0;
    drive(1'b1, 2'd3, 1'b1, LUT_A, 4'b0000);
    tick();
    chk("post_reset_route", 32'(out_valid), 32'h8);
    chk("post_reset_data", 32'(out_data), 32'h8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
